// File: rtl/wheel_pkg.sv
// Shared types and constants for the quadrature wheel front end.
package wheel_pkg;

    // Default distance accumulator width.
    localparam int ACC_W_DEF = 16;

    // ESP sub-code that carries the wheel ratio (add / dec).
    localparam logic [3:0] CMD_WHEEL_RATIO = 4'h2;

    // Quadrature states in forward order: 00 -> 01 -> 11 -> 10 -> 00.
    typedef enum logic [1:0] {
        Q_S0 = 2'b00,
        Q_S1 = 2'b01,
        Q_S2 = 2'b11,
        Q_S3 = 2'b10
    } quad_e;

    // Classification of one {A,B} transition.
    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_e;

    // Position of a state along the forward cycle.
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (quad_e'(ab))
            Q_S0:    pos = 2'd0;
            Q_S1:    pos = 2'd1;
            Q_S2:    pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // A distance of +1 along the cycle is forward, -1 reverse, 2 means both bits flipped.
    function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        step_e      s;
        d = quad_pos(cur) - quad_pos(prev);
        case (d)
            2'd0:    s = STEP_NONE;
            2'd1:    s = STEP_FWD;
            2'd3:    s = STEP_REV;
            default: s = STEP_ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wheel_sync_pin_filter.sv
// Two-flop synchronizer followed by a run-length debounce for one encoder pin.
module pin_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level
);

    // The level flips on the FILT_LEN-th consecutive differing sample.
    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q, cnt_d;
    logic       lvl_q, lvl_d;

    // Count differing samples; any agreeing sample restarts the run.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = 8'd0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_LAST) lvl_d = sync_q[1];
            else                   cnt_d = cnt_q + 8'd1;
        end
    end

    // Synchronizer and filter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            cnt_q  <= 8'd0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_pin};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign o_level = lvl_q;

endmodule

// File: rtl/wheel_sync.sv
// Quadrature decoder, signed way meter and distance-proportional sync generator.
module wheel_sync
    import wheel_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ch_a,
    input  logic        i_ch_b,
    input  logic [7:0]  i_wheel_add,
    input  logic [7:0]  i_frame_dec,
    output logic        o_ext_sync,
    output logic [31:0] o_way_meter,
    output logic        o_dir,
    output logic [7:0]  o_err_cnt
);

    // Headroom so step and drain can be combined before clamping.
    localparam int SW = ACC_W + 10;
    localparam logic signed [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

    logic f_a, f_b;
    logic [1:0] ab;

    pin_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst(rst), .i_pin(i_ch_a), .o_level(f_a)
    );
    pin_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst(rst), .i_pin(i_ch_b), .o_level(f_b)
    );

    assign ab = {f_a, f_b};

    logic             primed_q;
    logic [1:0]       ab_prev_q;
    logic [31:0]      way_q, way_d;
    logic             dir_q, dir_d;
    logic [7:0]       err_q, err_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       bl_q, bl_d;
    logic             sync_q, sync_d;
    step_e            step;

    logic signed [SW-1:0] acc_s, add_s, dec_s, sum_s;
    logic                 bl_inc, bl_dec;

    // Classify the transition; the first sample after reset only seeds the history.
    always_comb begin
        step  = primed_q ? quad_step(ab_prev_q, ab) : STEP_NONE;
        way_d = way_q;
        dir_d = dir_q;
        err_d = err_q;
        case (step)
            STEP_FWD: begin
                way_d = way_q + 32'd1;
                dir_d = 1'b1;
            end
            STEP_REV: begin
                way_d = way_q - 32'd1;
                dir_d = 1'b0;
            end
            STEP_ERR: if (err_q != 8'hFF) err_d = err_q + 8'd1;
            default: ;
        endcase
    end

    // Accumulate ground, drain one frame per cycle, let backlog swallow re-covered ground.
    always_comb begin
        acc_s  = SW'(acc_q);
        add_s  = SW'(i_wheel_add);
        dec_s  = SW'(i_frame_dec);
        sum_s  = acc_s;
        bl_inc = 1'b0;
        bl_dec = 1'b0;
        sync_d = 1'b0;
        acc_d  = '0;
        bl_d   = 8'd0;
        if (i_frame_dec != 8'd0) begin
            case (step)
                STEP_FWD: sum_s = sum_s + add_s;
                STEP_REV: begin
                    if (acc_s >= add_s) begin
                        sum_s = sum_s - add_s;
                    end else begin
                        // Borrow one frame: it is owed back before pulses resume.
                        sum_s  = sum_s + dec_s - add_s;
                        bl_inc = 1'b1;
                    end
                end
                default: ;
            endcase
            if (acc_s >= dec_s) begin
                sum_s = sum_s - dec_s;
                if (bl_q != 8'd0) bl_dec = 1'b1;
                else              sync_d = 1'b1;
            end
            if (sum_s[SW-1])          acc_d = '0;
            else if (sum_s > ACC_MAX) acc_d = '1;
            else                      acc_d = sum_s[ACC_W-1:0];
            bl_d = bl_q;
            if (bl_inc && !bl_dec) begin
                if (bl_q != 8'hFF) bl_d = bl_q + 8'd1;
            end else if (bl_dec && !bl_inc) begin
                bl_d = bl_q - 8'd1;
            end
        end
    end

    // Transition history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q  <= 1'b0;
            ab_prev_q <= 2'b00;
        end else begin
            primed_q  <= 1'b1;
            ab_prev_q <= ab;
        end
    end

    // Counters, accumulator and sync pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            way_q  <= 32'd0;
            dir_q  <= 1'b1;
            err_q  <= 8'd0;
            acc_q  <= '0;
            bl_q   <= 8'd0;
            sync_q <= 1'b0;
        end else begin
            way_q  <= way_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
            bl_q   <= bl_d;
            sync_q <= sync_d;
        end
    end

    assign o_ext_sync  = sync_q;
    assign o_way_meter = way_q;
    assign o_dir       = dir_q;
    assign o_err_cnt   = err_q;

endmodule
